add_inc16_unit: RTL and testbench



---
 rtl/add_inc16_unit_if.sv | 40 ++++
 rtl/add_inc16_unit.sv | 91 +++++++++
 tb/tb_add_inc16_unit.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_inc16_unit_if.sv
// Operand/result bundle for add_inc16_unit.
// ADD_INC16_FLAGS_EN adds the carry/overflow flag signals.
interface add_inc16_unit_if #(
   parameter int unsigned WIDTH = 16
) ();

   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic [WIDTH-1:0] add16;
   logic [WIDTH-1:0] inc16;

`ifdef ADD_INC16_FLAGS_EN
   logic add_cout;
   logic add_ovf;
   logic inc_cout;

   modport master (
      output in_valid, a, b,
      input  out_valid, add16, inc16, add_cout, add_ovf, inc_cout
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, add16, inc16, add_cout, add_ovf, inc_cout
   );
`else
   modport master (
      output in_valid, a, b,
      input  out_valid, add16, inc16
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, add16, inc16
   );
`endif

endinterface

// File: rtl/add_inc16_unit.sv
// Registered adder (a + b) and incrementer (a + 1) built from full/half-adder chains.
// Optional macro ADD_INC16_FLAGS_EN adds registered add_cout, add_ovf and inc_cout.
module add_inc16_unit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   add_inc16_unit_if.slave   bus
);

`ifdef ADD_INC16_FLAGS_EN
   localparam int unsigned CARRY_W = WIDTH + 1;
   localparam int unsigned MSB     = WIDTH - 1;
`else
   // Without flags the MSB carry-out is never built, so it cannot dangle.
   localparam int unsigned CARRY_W = WIDTH;
`endif

   logic [WIDTH-1:0]   a_c;
   logic [WIDTH-1:0]   b_c;
   logic [WIDTH-1:0]   sum_c;
   logic [WIDTH-1:0]   inc_c;
   logic [CARRY_W-1:0] add_carry_c;
   logic [CARRY_W-1:0] inc_carry_c;

   logic               valid_q;
   logic [WIDTH-1:0]   add_q;
   logic [WIDTH-1:0]   inc_q;

   assign a_c = bus.a;
   assign b_c = bus.b;

   assign add_carry_c[0] = 1'b0;
   assign inc_carry_c[0] = 1'b1;

   // Bit slices: one full adder (sum) and one half adder (increment) per bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum_c[i] = a_c[i] ^ b_c[i] ^ add_carry_c[i];
      assign inc_c[i] = a_c[i] ^ inc_carry_c[i];
      if (i + 1 < CARRY_W) begin : g_carry
         assign add_carry_c[i+1] = (a_c[i] & b_c[i]) | (add_carry_c[i] & (a_c[i] ^ b_c[i]));
         assign inc_carry_c[i+1] = a_c[i] & inc_carry_c[i];
      end
   end

   // Result registers: capture on in_valid, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin : p_result
      if (!rst_n) begin
         valid_q <= 1'b0;
         add_q   <= '0;
         inc_q   <= '0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            add_q <= sum_c;
            inc_q <= inc_c;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.add16     = add_q;
   assign bus.inc16     = inc_q;

`ifdef ADD_INC16_FLAGS_EN
   logic add_ovf_c;
   logic add_cout_q;
   logic add_ovf_q;
   logic inc_cout_q;

   // Signed overflow: operands agree in sign but the sum does not.
   assign add_ovf_c = (a_c[MSB] == b_c[MSB]) && (sum_c[MSB] != a_c[MSB]);

   always_ff @(posedge clk or negedge rst_n) begin : p_flags
      if (!rst_n) begin
         add_cout_q <= 1'b0;
         add_ovf_q  <= 1'b0;
         inc_cout_q <= 1'b0;
      end else if (bus.in_valid) begin
         add_cout_q <= add_carry_c[WIDTH];
         add_ovf_q  <= add_ovf_c;
         inc_cout_q <= inc_carry_c[WIDTH];
      end
   end

   assign bus.add_cout = add_cout_q;
   assign bus.add_ovf  = add_ovf_q;
   assign bus.inc_cout = inc_cout_q;
`endif

endmodule

// File: tb/tb_add_inc16_unit.sv
// Scoreboard bench for add_inc16_unit; flag checks follow ADD_INC16_FLAGS_EN.
module tb_add_inc16_unit;

   typedef struct packed {
      logic [15:0] add;
      logic [15:0] inc;
      logic        add_cout;
      logic        add_ovf;
      logic        inc_cout;
   } exp_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   exp_t sb[$];
   exp_t last;

   add_inc16_unit_if #(.WIDTH(16)) bus ();

   add_inc16_unit #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model using wide and signed integer arithmetic.
   function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv);
      exp_t        e;
      logic [16:0] s;
      logic [16:0] n;
      int          ss;
      s  = {1'b0, av} + {1'b0, bv};
      n  = {1'b0, av} + 17'd1;
      ss = int'($signed(av)) + int'($signed(bv));
      e.add      = s[15:0];
      e.inc      = n[15:0];
      e.add_cout = s[16];
      e.inc_cout = n[16];
      e.add_ovf  = (ss > 32767) || (ss < -32768);
      return e;
   endfunction

   task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv);
      @(negedge clk);
      bus.in_valid = v;
      bus.a        = av;
      bus.b        = bv;
      if (v) sb.push_back(model(av, bv));
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = 16'h0001;
      bus.b        = 16'h0001;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.add16 !== 16'h0000 || bus.inc16 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state got v=%0b add=%h inc=%h exp v=0 add=0000 inc=0000",
                  bus.out_valid, bus.add16, bus.inc16);
      end
`ifdef ADD_INC16_FLAGS_EN
      checks++;
      if ({bus.add_cout, bus.add_ovf, bus.inc_cout} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 000", {bus.add_cout, bus.add_ovf, bus.inc_cout});
      end
`endif
      @(negedge clk);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      last         = '0;
   endtask

   task automatic test_corners();
      logic [15:0] va [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hAAAA};
      logic [15:0] vb [4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h5555};
      logic [15:0] ea [4] = '{16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFF};
      logic [15:0] ei [4] = '{16'h0001, 16'h0001, 16'h0000, 16'hAAAB};
      exp_t        e;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, va[i], vb[i]);
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.add16 !== ea[i] || bus.inc16 !== ei[i]) begin
            errors++;
            $display("FAIL corner[%0d] got v=%0b add=%h inc=%h exp v=1 add=%h inc=%h",
                     i, bus.out_valid, bus.add16, bus.inc16, ea[i], ei[i]);
         end
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL corner_sb[%0d] got empty scoreboard exp entry", i);
         end else begin
            e    = sb.pop_front();
            last = e;
            if (bus.add16 !== e.add || bus.inc16 !== e.inc) begin
               errors++;
               $display("FAIL corner_model[%0d] got add=%h inc=%h exp add=%h inc=%h",
                        i, bus.add16, bus.inc16, e.add, e.inc);
            end
`ifdef ADD_INC16_FLAGS_EN
            checks++;
            if ({bus.add_cout, bus.add_ovf, bus.inc_cout} !== {e.add_cout, e.add_ovf, e.inc_cout}) begin
               errors++;
               $display("FAIL corner_flags[%0d] got %b exp %b", i,
                        {bus.add_cout, bus.add_ovf, bus.inc_cout}, {e.add_cout, e.add_ovf, e.inc_cout});
            end
`endif
         end
      end
   endtask

   task automatic test_hold();
      drive(1'b0, 16'h1234, 16'h0F0F);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b0 || bus.add16 !== 16'hFFFF || bus.inc16 !== 16'hAAAB) begin
            errors++;
            $display("FAIL hold[%0d] got v=%0b add=%h inc=%h exp v=0 add=ffff inc=aaab",
                     i, bus.out_valid, bus.add16, bus.inc16);
         end
         bus.a = 16'h4321;
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] va [2] = '{16'h7FFF, 16'h8000};
      logic [15:0] vb [2] = '{16'h0001, 16'h8000};
      logic [15:0] ea [2] = '{16'h8000, 16'h0000};
      exp_t        e;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, va[i], vb[i]);
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.add16 !== ea[i]) begin
            errors++;
            $display("FAIL b2b[%0d] got v=%0b add=%h exp v=1 add=%h",
                     i, bus.out_valid, bus.add16, ea[i]);
         end
         if (sb.size() != 0) begin
            e    = sb.pop_front();
            last = e;
            checks++;
            if (bus.inc16 !== e.inc) begin
               errors++;
               $display("FAIL b2b_inc[%0d] got %h exp %h", i, bus.inc16, e.inc);
            end
         end
`ifdef ADD_INC16_FLAGS_EN
         checks++;
         if (bus.add_ovf !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ovf[%0d] got %0b exp 1", i, bus.add_ovf);
         end
`endif
      end
   endtask

   task automatic test_random();
      logic        v;
      logic [15:0] av;
      logic [15:0] bv;
      exp_t        e;
      for (int i = 0; i < 40; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         av = 16'($urandom());
         bv = 16'($urandom());
         if (i % 8 == 3) av = 16'hFFFF;
         drive(v, av, bv);
         @(posedge clk);
         #1;
         if (v) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rand_sb[%0d] got empty scoreboard exp entry", i);
            end else begin
               e    = sb.pop_front();
               last = e;
               if (bus.out_valid !== 1'b1 || bus.add16 !== e.add || bus.inc16 !== e.inc) begin
                  errors++;
                  $display("FAIL rand[%0d] a=%h b=%h got v=%0b add=%h inc=%h exp v=1 add=%h inc=%h",
                           i, av, bv, bus.out_valid, bus.add16, bus.inc16, e.add, e.inc);
               end
            end
         end else begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.add16 !== last.add || bus.inc16 !== last.inc) begin
               errors++;
               $display("FAIL rand_hold[%0d] got v=%0b add=%h inc=%h exp v=0 add=%h inc=%h",
                        i, bus.out_valid, bus.add16, bus.inc16, last.add, last.inc);
            end
         end
`ifdef ADD_INC16_FLAGS_EN
         checks++;
         if ({bus.add_cout, bus.add_ovf, bus.inc_cout} !== {last.add_cout, last.add_ovf, last.inc_cout}) begin
            errors++;
            $display("FAIL rand_flags[%0d] got %b exp %b", i,
                     {bus.add_cout, bus.add_ovf, bus.inc_cout}, {last.add_cout, last.add_ovf, last.inc_cout});
         end
`endif
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      drive(1'b1, 16'h1234, 16'h4321);
      @(posedge clk);
      #1;
      if (sb.size() != 0) last = sb.pop_front();
      checks++;
      if (bus.add16 !== 16'h5555 || bus.inc16 !== 16'h1235) begin
         errors++;
         $display("FAIL pre_reset got add=%h inc=%h exp add=5555 inc=1235", bus.add16, bus.inc16);
      end
      drive(1'b1, 16'hFFFF, 16'h0001);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.add16 !== 16'h0000 || bus.inc16 !== 16'h0000) begin
         errors++;
         $display("FAIL async_reset got v=%0b add=%h inc=%h exp v=0 add=0000 inc=0000",
                  bus.out_valid, bus.add16, bus.inc16);
      end
      sb.delete();
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.add16 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_priority got v=%0b add=%h exp v=0 add=0000", bus.out_valid, bus.add16);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back(model(16'hFFFF, 16'h0001));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      last = e;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.add16 !== 16'h0000 || bus.inc16 !== 16'h0000) begin
         errors++;
         $display("FAIL first_capture got v=%0b add=%h inc=%h exp v=1 add=0000 inc=0000",
                  bus.out_valid, bus.add16, bus.inc16);
      end
`ifdef ADD_INC16_FLAGS_EN
      checks++;
      if ({bus.add_cout, bus.add_ovf, bus.inc_cout} !== {e.add_cout, e.add_ovf, e.inc_cout}) begin
         errors++;
         $display("FAIL first_capture_flags got %b exp %b",
                  {bus.add_cout, bus.add_ovf, bus.inc_cout}, {e.add_cout, e.add_ovf, e.inc_cout});
      end
`endif
      drive(1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_corners();
      test_hold();
      test_back_to_back();
      test_random();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d entries exp 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
